// File: rtl/intr_ctrl.sv
// Interrupt front-end: synchronises and debounces INTR, latches a pending request,
// sequences take/handler/return and drives the trap or return PC to the PC mux.
module intr_ctrl #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int CNT_W        = 3
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        INTR,
    input  logic        CSR_MIE,
    input  logic [31:0] CSR_MTVEC,
    input  logic [31:0] CSR_MEPC,
    input  logic        INSTR_DONE,
    input  logic        MRET,
    output logic        INT_TAKEN,
    output logic        PC_SEL_TRAP,
    output logic [31:0] TRAP_PC,
    output logic        INT_PENDING,
    output logic        IN_ISR
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TAKE   = 2'd1,
        S_ISR    = 2'd2,
        S_RETURN = 2'd3
    } state_t;

    state_t           state;
    logic             sync1;
    logic             s_intr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             valid;
    logic             valid_nxt;
    logic             req_edge;
    logic             pending;

    always_comb begin
        cnt_nxt = cnt;
        if (!s_intr) begin
            cnt_nxt = '0;
        end else if (cnt != CNT_MAX) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    // Edge is taken on the counter update itself so pending rises with 'valid'.
    assign valid     = (cnt == CNT_MAX);
    assign valid_nxt = (cnt_nxt == CNT_MAX);
    assign req_edge  = valid_nxt & ~valid;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1   <= 1'b0;
            s_intr  <= 1'b0;
            cnt     <= '0;
            pending <= 1'b0;
        end else begin
            sync1   <= INTR;
            s_intr  <= sync1;
            cnt     <= cnt_nxt;
            pending <= req_edge | (pending & ~INT_TAKEN);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= S_IDLE;
            INT_TAKEN   <= 1'b0;
            PC_SEL_TRAP <= 1'b0;
            IN_ISR      <= 1'b0;
        end else begin
            INT_TAKEN   <= 1'b0;
            PC_SEL_TRAP <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pending && CSR_MIE && INSTR_DONE && !MRET) begin
                        state       <= S_TAKE;
                        INT_TAKEN   <= 1'b1;
                        PC_SEL_TRAP <= 1'b1;
                    end
                end
                S_TAKE: begin
                    state  <= S_ISR;
                    IN_ISR <= 1'b1;
                end
                S_ISR: begin
                    if (MRET && INSTR_DONE) begin
                        state       <= S_RETURN;
                        PC_SEL_TRAP <= 1'b1;
                        IN_ISR      <= 1'b0;
                    end
                end
                S_RETURN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state  <= S_IDLE;
                    IN_ISR <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        TRAP_PC = 32'h0;
        case (state)
            S_TAKE:   TRAP_PC = CSR_MTVEC;
            S_RETURN: TRAP_PC = CSR_MEPC;
            default:  TRAP_PC = 32'h0;
        endcase
    end

    assign INT_PENDING = pending;

endmodule
